// File: rtl/dotp_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined dot-product unit.
package dotp_pkg;

  localparam int DOTP_LATENCY = 3;

  // Bit offset of lane `lane` inside a flattened LANES*WIDTH operand bus.
  function automatic int dotp_lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

  // Ceiling log2; LANES=1 yields depth 0 (no adder levels).
  function automatic int dotp_log2(input int value);
    int depth = 0;
    while ((1 << depth) < value) depth++;
    return depth;
  endfunction

endpackage

// File: rtl/dotp_adder_tree.sv
// Combinational pairwise modulo-2^WIDTH reduction of LANES terms to one sum.
module dotp_adder_tree
  import dotp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LANES = 2
) (
  input  logic [LANES*WIDTH-1:0] i_terms,
  output logic [WIDTH-1:0]       o_sum
);

  localparam int DEPTH = dotp_log2(LANES);

  if (LANES < 1 || LANES > 16 || LANES != (1 << DEPTH)) begin : g_bad_lanes
    $error("dotp_adder_tree: LANES must be a power of two between 1 and 16");
  end

  // Level l holds LANES>>l partial sums; level DEPTH is the single root.
  for (genvar l = 0; l <= DEPTH; l++) begin : g_lvl
    logic [WIDTH-1:0] w_sum [LANES >> l];
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < LANES; i++) begin : g_in
        assign w_sum[i] = i_terms[dotp_lane_lsb(i, WIDTH) +: WIDTH];
      end
    end else begin : g_add
      for (genvar i = 0; i < (LANES >> l); i++) begin : g_pair
        assign w_sum[i] = g_lvl[l-1].w_sum[2*i] + g_lvl[l-1].w_sum[2*i+1];
      end
    end
  end

  assign o_sum = g_lvl[DEPTH].w_sum[0];

endmodule

// File: rtl/pipelined_dot_product.sv
// Three-stage valid/ready multiply-accumulate pipeline: c = sum(a[i]*b[i]),
// optionally added to a running accumulator.
module pipelined_dot_product
  import dotp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LANES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] a,
  input  logic [LANES*WIDTH-1:0] b,
  input  logic                   acc_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       c
);

  localparam int S1 = 0;
  localparam int S2 = 1;
  localparam int S3 = 2;

  logic [DOTP_LATENCY-1:0] r_valid;
  logic [LANES*WIDTH-1:0]  r_s1_a;
  logic [LANES*WIDTH-1:0]  r_s1_b;
  logic                    r_s1_acc_en;
  logic [LANES*WIDTH-1:0]  r_s2_prod;
  logic                    r_s2_acc_en;
  logic [WIDTH-1:0]        r_c;
  logic [WIDTH-1:0]        r_acc;

  logic                    w_s3_load_ok;
  logic                    w_s2_moves;
  logic                    w_s2_load_ok;
  logic                    w_s1_moves;
  logic                    w_in_fire;
  logic [LANES*WIDTH-1:0]  w_prod;
  logic [WIDTH-1:0]        w_sum;
  logic [WIDTH-1:0]        w_result;

  // Ready ripples back from out_ready only; in_valid never reaches in_ready.
  assign w_s3_load_ok = !r_valid[S3] || out_ready;
  assign w_s2_moves   = r_valid[S2] && w_s3_load_ok;
  assign w_s2_load_ok = !r_valid[S2] || w_s2_moves;
  assign w_s1_moves   = r_valid[S1] && w_s2_load_ok;
  assign in_ready     = !r_valid[S1] || w_s1_moves;
  assign w_in_fire    = in_valid && in_ready;

  for (genvar i = 0; i < LANES; i++) begin : g_mul
    assign w_prod[dotp_lane_lsb(i, WIDTH) +: WIDTH] =
      r_s1_a[dotp_lane_lsb(i, WIDTH) +: WIDTH] * r_s1_b[dotp_lane_lsb(i, WIDTH) +: WIDTH];
  end

  dotp_adder_tree #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) u_tree (
    .i_terms (r_s2_prod),
    .o_sum   (w_sum)
  );

  assign w_result = r_s2_acc_en ? (r_acc + w_sum) : w_sum;

  // NOTE: non-blocking assignments so each stage captures its neighbour's pre-edge value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_c     <= '0;
      r_acc   <= '0;
    end else begin
      if (in_ready)     r_valid[S1] <= in_valid;
      if (w_s2_load_ok) r_valid[S2] <= r_valid[S1];
      if (w_s3_load_ok) r_valid[S3] <= r_valid[S2];
      if (w_s2_moves) begin
        r_c   <= w_result;
        r_acc <= w_result;
      end
    end
  end

  // NOTE: operand and product registers are qualified by their valid bits, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_s1_a      <= a;
      r_s1_b      <= b;
      r_s1_acc_en <= acc_en;
    end
    if (w_s1_moves) begin
      r_s2_prod   <= w_prod;
      r_s2_acc_en <= r_s1_acc_en;
    end
  end

  assign out_valid = r_valid[S3];
  assign c         = r_c;

endmodule

// File: tb/tb_pipelined_dot_product.sv
// Bench for pipelined_dot_product: LANES=1/2/4 instances share stimulus; a
// reference model feeds per-instance expected-result queues.
module tb_pipelined_dot_product;

  localparam int W           = 32;
  localparam int EXP_LATENCY = 3;

  logic           clk       = 1'b0;
  logic           reset     = 1'b1;
  logic           in_valid  = 1'b0;
  logic           out_ready = 1'b1;
  logic           acc_en    = 1'b0;
  logic [4*W-1:0] a_bus     = '0;
  logic [4*W-1:0] b_bus     = '0;

  logic           ir1, ir2, ir4, ov1, ov2, ov4;
  logic [W-1:0]   c1, c2, c4;
  logic [2:0]     ir, ov;
  logic [W-1:0]   cc [3];

  assign ir    = {ir4, ir2, ir1};
  assign ov    = {ov4, ov2, ov1};
  assign cc[0] = c1;
  assign cc[1] = c2;
  assign cc[2] = c4;

  always #5 clk = ~clk;

  pipelined_dot_product #(.WIDTH(W), .LANES(1)) dut_l1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir1),
    .a(a_bus[W-1:0]), .b(b_bus[W-1:0]), .acc_en(acc_en),
    .out_valid(ov1), .out_ready(out_ready), .c(c1));

  pipelined_dot_product #(.WIDTH(W), .LANES(2)) dut_l2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir2),
    .a(a_bus[2*W-1:0]), .b(b_bus[2*W-1:0]), .acc_en(acc_en),
    .out_valid(ov2), .out_ready(out_ready), .c(c2));

  pipelined_dot_product #(.WIDTH(W), .LANES(4)) dut_l4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir4),
    .a(a_bus), .b(b_bus), .acc_en(acc_en),
    .out_valid(ov4), .out_ready(out_ready), .c(c4));

  int           errors  = 0;
  int           checks  = 0;
  int           accepts = 0;
  bit           done    = 1'b0;
  logic [W-1:0] q1 [$];
  logic [W-1:0] q2 [$];
  logic [W-1:0] q4 [$];
  logic [W-1:0] m_acc [3] = '{default: '0};
  logic [2:0]   hold_prev = '0;
  logic [W-1:0] prev_c [3];
  logic [W-1:0] mon_exp;

  typedef struct {
    logic [4*W-1:0] a;
    logic [4*W-1:0] b;
    logic           acc_en;
    logic [W-1:0]   exp_c;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_ctrl(input string name, input logic exp_ir, input logic exp_ov);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_in_ready_l%0d", name, 1 << k), W'(ir[k]), W'(exp_ir));
      check($sformatf("%s_out_valid_l%0d", name, 1 << k), W'(ov[k]), W'(exp_ov));
    end
  endtask

  function automatic logic [W-1:0] model_sum(input logic [4*W-1:0] av, input logic [4*W-1:0] bv,
                                             input int lanes);
    logic [W-1:0] s = '0;
    logic [W-1:0] p;
    for (int i = 0; i < lanes; i++) begin
      p = av[i*W +: W] * bv[i*W +: W];
      s = s + p;
    end
    return s;
  endfunction

  function automatic logic [4*W-1:0] rnd_bus();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic push_expect(input logic [4*W-1:0] av, input logic [4*W-1:0] bv, input logic ae);
    logic [W-1:0] s;
    for (int k = 0; k < 3; k++) begin
      s        = model_sum(av, bv, 1 << k);
      m_acc[k] = ae ? (m_acc[k] + s) : s;
    end
    q1.push_back(m_acc[0]);
    q2.push_back(m_acc[1]);
    q4.push_back(m_acc[2]);
  endtask

  function automatic bit pop_expect(input int k, output logic [W-1:0] v);
    v = '0;
    if (k == 0) begin
      if (q1.size() == 0) return 1'b0;
      v = q1.pop_front();
    end else if (k == 1) begin
      if (q2.size() == 0) return 1'b0;
      v = q2.pop_front();
    end else begin
      if (q4.size() == 0) return 1'b0;
      v = q4.pop_front();
    end
    return 1'b1;
  endfunction

  // Offer one beat at a negedge and hold it until in_ready; the handshake edge follows.
  task automatic send(input logic [4*W-1:0] av, input logic [4*W-1:0] bv, input logic ae);
    int guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    a_bus    = av;
    b_bus    = bv;
    acc_en   = ae;
    #1;
    while (!ir2 && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!ir2) begin
      check("send_timeout", W'(ir2), 1);
      in_valid = 1'b0;
    end else begin
      push_expect(av, bv, ae);
      accepts++;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_out(input string name, input logic [W-1:0] exp_c);
    int n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (!ov2 && n < 20);
    check({name, "_latency"}, W'(n), EXP_LATENCY);
    check({name, "_c"}, c2, exp_c);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((q1.size() + q2.size() + q4.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_left_l1"}, W'(q1.size()), 0);
    check({name, "_left_l2"}, W'(q2.size()), 0);
    check({name, "_left_l4"}, W'(q4.size()), 0);
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    reset = 1'b1;
    q1.delete();
    q2.delete();
    q4.delete();
    foreach (m_acc[k]) m_acc[k] = '0;
    @(negedge clk);
    #1;
    check_ctrl(name, 1'b1, 1'b0);
    check({name, "_c"}, c2, 0);
    reset = 1'b0;
  endtask

  // Scoreboard monitor: samples mid-low-phase, compares every transfer and every stall hold.
  always begin
    @(negedge clk);
    #2;
    if (reset) begin
      hold_prev = '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (hold_prev[k]) begin
          check($sformatf("hold_valid_l%0d", 1 << k), W'(ov[k]), 1);
          check($sformatf("hold_c_l%0d", 1 << k), cc[k], prev_c[k]);
        end
        if (ov[k] && out_ready) begin
          if (pop_expect(k, mon_exp)) check($sformatf("result_l%0d", 1 << k), cc[k], mon_exp);
          else check($sformatf("spurious_l%0d", 1 << k), W'(ov[k]), 0);
        end
        hold_prev[k] = ov[k] && !out_ready;
        prev_c[k]    = cc[k];
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{{64'd0, 32'd1, 32'd2}, {64'd0, 32'd1, 32'd2}, 1'b1, 32'd5};
    vecs[1] = '{{64'd0, 32'd1, 32'd3}, {64'd0, 32'd1, 32'd2}, 1'b1, 32'd12};
    vecs[2] = '{{64'd0, 32'd2, 32'd2}, {64'd0, 32'd2, 32'd3}, 1'b1, 32'd22};
    vecs[3] = '{{64'd0, 32'd0, 32'd2}, {64'd0, 32'd0, 32'd2}, 1'b0, 32'd4};
    vecs[4] = '{{64'd0, 32'd0, 32'd0}, {64'd0, 32'd0, 32'd0}, 1'b1, 32'd4};
    vecs[5] = '{{64'd0, 32'hFFFF_FFFF, 32'd1}, {64'd0, 32'd2, 32'd1}, 1'b0, 32'hFFFF_FFFF};
    vecs[6] = '{{64'd0, 32'h4000_0000, 32'h4000_0000}, {64'd0, 32'd2, 32'd2}, 1'b0, 32'd0};

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check_ctrl("reset", 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) check($sformatf("reset_c_l%0d", 1 << k), cc[k], 0);
    reset = 1'b0;

    // Two back-to-back beats, both sum 6: exact latency and two consecutive valid cycles.
    send({64'd0, 32'd2, 32'd0}, {64'd0, 32'd3, 32'd1}, 1'b0);
    send({64'd0, 32'd1, 32'd3}, {64'd0, 32'd0, 32'd2}, 1'b0);
    @(negedge clk); #2; check_ctrl("t1_edge1", 1'b1, 1'b0);
    @(negedge clk); #2; check_ctrl("t1_edge2", 1'b1, 1'b1); check("t1_c_first", c2, 6);
    @(negedge clk); #2; check_ctrl("t1_edge3", 1'b1, 1'b1); check("t1_c_second", c2, 6);
    @(negedge clk); #2; check_ctrl("t1_edge4", 1'b1, 1'b0);

    // Accumulate sequence, restart, and wrap-around vectors.
    do_reset("t2_reset");
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].acc_en);
      wait_out($sformatf("vec%0d", i), vecs[i].exp_c);
    end

    // Back-pressure: three accepts fill the pipe, beats 4 and 5 wait for draining.
    @(negedge clk);
    out_ready = 1'b0;
    accepts   = 0;
    send(rnd_bus(), rnd_bus(), 1'b0);
    send(rnd_bus(), rnd_bus(), 1'b1);
    check_ctrl("t3_two_in", 1'b1, 1'b0);
    send(rnd_bus(), rnd_bus(), 1'b1);
    fork
      begin
        send(rnd_bus(), rnd_bus(), 1'b1);
        send(rnd_bus(), rnd_bus(), 1'b0);
      end
      begin
        repeat (3) begin
          @(negedge clk);
          #2;
          check_ctrl("t3_full", 1'b0, 1'b1);
          check("t3_accepts", W'(accepts), 3);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check_ctrl("t3_release", 1'b1, 1'b1);
      end
    join
    wait_drain("t3");
    check("t3_total_accepts", W'(accepts), 5);

    // Reset with two beats in flight and acc=9.
    send({64'd0, 32'd0, 32'd3}, {64'd0, 32'd0, 32'd3}, 1'b0);
    wait_out("t5_acc9", 9);
    send(rnd_bus(), rnd_bus(), 1'b1);
    send(rnd_bus(), rnd_bus(), 1'b1);
    do_reset("t5_reset");
    repeat (3) begin
      @(negedge clk);
      #2;
      check_ctrl("t5_flushed", 1'b1, 1'b0);
    end
    send({64'd0, 32'd1, 32'd1}, {64'd0, 32'd1, 32'd2}, 1'b1);
    wait_out("t5_after", 3);

    // Random valid/ready traffic on all three lane counts.
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 200; n++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          send(rnd_bus(), rnd_bus(), 1'($urandom_range(0, 1)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
